// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared FSM encoding and rw constants for the memory request master
package mem_req_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
  localparam logic RW_READ = 1'b0;
  localparam logic RW_WRITE = 1'b1;
endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: synchronous command FIFO with full/empty, head visible combinationally
module mem_req_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0] wptr, rptr;
  assign full = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign empty = wptr == rptr;
  assign rdata = mem[rptr[PW-1:0]];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wptr[PW-1:0]] <= wdata;
endmodule

// File: rtl/mem_request_master.sv
// mem_request_master: buffers core load/store commands and issues them on the enable/rw/Wait bus
// Optional MEM_REQ_TIMEOUT_EN aborts a transaction after TIMEOUT_CYCLES of mem_wait with rsp_err.
module mem_request_master
  import mem_req_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_rw,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  output logic                     rsp_valid,
  output logic                     rsp_rw,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     mem_enable,
  output logic                     mem_rw,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_wait
);
  typedef struct packed {
    logic                     rw;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
  } cmd_t;
  cmd_t head;
  state_t state, state_nx;
  logic full, empty, pop, ok, tmo, done_q;
  mem_req_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid && cmd_ready),
    .pop   (pop),
    .wdata ({cmd_rw, cmd_addr, cmd_wdata}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
`ifdef MEM_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  assign tmo = state == BUSY && mem_wait && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) tcnt <= '0;
    else tcnt <= state == BUSY && mem_wait ? tcnt + 1'b1 : '0;
`else
  assign tmo = 1'b0;
`endif
  assign ok = state == BUSY && !mem_wait;
  assign pop = !empty && (state == IDLE || ok);
  assign cmd_ready = !full;
  assign busy = state != IDLE || !empty;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (empty ? IDLE : ISSUE)
             : state == ISSUE ? (mem_enable && !mem_wait ? BUSY : ISSUE)
             : ok             ? (empty ? IDLE : ISSUE)
             : tmo            ? IDLE : BUSY;
  end
  // enable rises one cycle after ISSUE entry, giving 3 cycles per back-to-back command
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      mem_enable  <= 1'b0;
      mem_rw      <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      done_q      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rw      <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state      <= state_nx;
      mem_enable <= state == ISSUE && state_nx == ISSUE;
      if (pop) {mem_rw, mem_address, mem_wdata} <= head;
      done_q    <= ok || tmo;
      rsp_valid <= done_q;
      if (ok || tmo) begin
        rsp_rw    <= mem_rw;
        rsp_rdata <= ok && mem_rw == RW_READ ? mem_rdata : '0;
        rsp_err   <= tmo;
      end
    end
endmodule

// File: tb/tb_mem_request_master.sv
// tb_mem_request_master: randomized scoreboard bench with a memory-controller stub
module tb_mem_request_master;
  import mem_req_pkg::*;
  localparam int AW = 32, DW = 32, DEPTH = 4, TMO = 16;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_rw = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic cmd_ready, rsp_valid, rsp_rw, rsp_err, busy, mem_enable, mem_rw, mem_wait;
  logic [DW-1:0] rsp_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_address;

  mem_request_master #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rw(rsp_rw),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .mem_enable(mem_enable), .mem_rw(mem_rw),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_wait(mem_wait)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // controller stub: misses add miss_wait Wait cycles after the enable is seen; hang holds Wait
  int miss_wait = 1, wcnt = 0;
  bit hang = 1'b0, hang_act = 1'b0;
  logic [DW-1:0] smem [1024];
  bit swr [1024];
  bit scached [1024];
  assign mem_wait = hang_act || wcnt != 0;
  always @(posedge clk or posedge reset)
    if (reset) begin
      wcnt <= 0;
      hang_act <= 1'b0;
      scached[4] <= 1'b1;
    end else if (mem_enable && !mem_wait) begin
      if (mem_rw == RW_WRITE) begin
        smem[mem_address[11:2]] <= mem_wdata;
        swr[mem_address[11:2]] <= 1'b1;
      end
      mem_rdata <= swr[mem_address[11:2]] ? smem[mem_address[11:2]] : mem_address >> 2;
      scached[mem_address[11:2]] <= 1'b1;
      wcnt <= scached[mem_address[11:2]] ? 0 : miss_wait;
      hang_act <= hang;
    end else begin
      if (wcnt != 0) wcnt <= wcnt - 1;
      if (!hang) hang_act <= 1'b0;
    end

  typedef struct {
    logic rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic err;
  } exp_t;
  exp_t sb[$];
  exp_t em;
  logic [DW-1:0] ref_mem [1024];
  bit ref_wr [1024];
  int checks = 0, failures = 0;
  int rsp_cnt = 0, last_rsp_cyc = 0, en_pulses = 0;
  logic en_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h @cycle %0d", name, act, exp, cyc);
    end
  endtask

  // reference: commands complete in order; reads return last written value or addr>>2
  task automatic expect_cmd(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic err);
    exp_t e;
    e.rw = rw; e.addr = a; e.wdata = d; e.err = err;
    e.rdata = (rw == RW_WRITE || err) ? '0 : (ref_wr[a[11:2]] ? ref_mem[a[11:2]] : a >> 2);
    if (rw == RW_WRITE && !err) begin
      ref_mem[a[11:2]] = d;
      ref_wr[a[11:2]] = 1'b1;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk)
    if (!reset) begin
      if (rsp_valid) begin
        rsp_cnt++;
        last_rsp_cyc = cyc;
        if (sb.size() == 0) chk("unexpected_rsp", sb.size(), 1);
        else begin
          em = sb.pop_front();
          chk("rsp_rw", rsp_rw, em.rw);
          chk("rsp_rdata", rsp_rdata, em.rdata);
          chk("rsp_err", rsp_err, em.err);
        end
      end
      if ((mem_enable || mem_wait) && sb.size() != 0) begin
        chk("mem_address", mem_address, sb[0].addr);
        chk("mem_rw", mem_rw, sb[0].rw);
        if (sb[0].rw == RW_WRITE) chk("mem_wdata", mem_wdata, sb[0].wdata);
      end
      if (mem_enable && !en_prev) en_pulses++;
      en_prev = mem_enable;
    end

  // call at a negedge; returns at the negedge after the accept edge
  task automatic push(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic err, output int acc);
    int n = 0;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    acc = cyc + 1;
    if (!cmd_ready) chk("cmd_ready_bound", cmd_ready, 1);
    else expect_cmd(rw, a, d, err);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n0);
    int k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (rsp_cnt == n0 && k < 100);
    if (rsp_cnt == n0) chk("rsp_bound", rsp_cnt, n0 + 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("drain_sb", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n0, en0, acc_n, k;
    logic rw;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_mem_enable", mem_enable, 0);
    chk("reset_mem_address", mem_address, 0);
    reset = 1'b0;
    @(negedge clk);

    n0 = rsp_cnt;
    push(RW_READ, 32'h10, '0, 1'b0, acc);
    repeat (2) @(negedge clk);
    chk("hit_enable_cycle2", mem_enable, 1);
    wait_rsp(n0);
    chk("hit_latency", last_rsp_cyc - acc, 5);

    miss_wait = 1;
    n0 = rsp_cnt;
    push(RW_READ, 32'h200, '0, 1'b0, acc);
    wait_rsp(n0);
    chk("miss_latency", last_rsp_cyc - acc, 6);

    push(RW_WRITE, 32'h40, 32'hDEADBEEF, 1'b0, acc);
    push(RW_READ, 32'h40, '0, 1'b0, acc);
    wait_idle();

    miss_wait = 8;
    en0 = en_pulses;
    acc_n = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cmd_rw = 1'($urandom_range(0, 1));
      cmd_addr = 32'h300 + 32'(acc_n * 4);
      cmd_wdata = $urandom;
      if (cmd_ready) begin
        expect_cmd(cmd_rw, cmd_addr, cmd_wdata, 1'b0);
        acc_n++;
      end
      @(negedge clk);
    end
    chk("full_accepted", acc_n, DEPTH + 1);
    chk("full_cmd_ready", cmd_ready, 0);
    cmd_valid = 1'b0;
    wait_idle();
    chk("full_enable_pulses", en_pulses - en0, acc_n);

    miss_wait = 6;
    n0 = rsp_cnt;
    push(RW_READ, 32'h380, '0, 1'b0, acc);
    k = 0;
    while (!mem_wait && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rst_wait_seen", mem_wait, 1);
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_enable", mem_enable, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("rst_no_rsp", rsp_cnt, n0);

`ifdef MEM_REQ_TIMEOUT_EN
    hang = 1'b1;
    n0 = rsp_cnt;
    push(RW_READ, 32'h10, '0, 1'b1, acc);
    wait_rsp(n0);
    chk("tmo_latency", last_rsp_cyc - acc, TMO + 4);
    chk("tmo_idle", busy, 0);
    hang = 1'b0;
    repeat (3) @(negedge clk);
`endif

    for (int i = 0; i < 40; i++) begin
      miss_wait = $urandom_range(1, 3);
      rw = 1'($urandom_range(0, 1));
      push(rw, 32'h400 + 32'($urandom_range(0, 31)) * 4, $urandom, 1'b0, acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    chk("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
